// File: rtl/sequenciador_operandos_pkg.sv
// rtl/sequenciador_operandos_pkg.sv - shared state encoding and widths for the operand sequencer
package sequenciador_pkg;

    localparam int LARGURA_OP  = 4;
    localparam int LARGURA_RES = 5;

    typedef enum logic [1:0] {
        ESPERA_A = 2'd0,
        ESPERA_B = 2'd1,
        CALCULA  = 2'd2,
        MOSTRA   = 2'd3
    } estado_t;

endpackage

// File: rtl/sequenciador_operandos_if.sv
// rtl/sequenciador_operandos_if.sv - bit-level link between the sequencer and the external 4-bit adder
interface sequenciador_operandos_if;
    import sequenciador_pkg::*;

    logic [LARGURA_OP-1:0] a_op;
    logic [LARGURA_OP-1:0] b_op;
    logic                  cin;
    logic [LARGURA_OP-1:0] soma_in;
    logic                  cout_in;

    modport master (
        output a_op,
        output b_op,
        output cin,
        input  soma_in,
        input  cout_in
    );

    modport slave (
        input  a_op,
        input  b_op,
        input  cin,
        output soma_in,
        output cout_in
    );

endinterface

// File: rtl/sequenciador_operandos_filtro_botao.sv
// rtl/sequenciador_operandos_filtro_botao.sv - button synchronizer, debounce filter and press pulse
module filtro_botao #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    output logic pulso
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sinc_1;
    logic          sinc_2;
    logic          filtrado;
    logic          filtrado_q;
    logic [CW-1:0] contador;

    // Level flips on the D-th consecutive cycle that the synchronized input disagrees with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sinc_1     <= 1'b0;
            sinc_2     <= 1'b0;
            filtrado   <= 1'b0;
            filtrado_q <= 1'b0;
            contador   <= '0;
        end else begin
            sinc_1     <= botao;
            sinc_2     <= sinc_1;
            filtrado_q <= filtrado;
            if (sinc_2 == filtrado) begin
                contador <= '0;
            end else if (contador == CW'(DEBOUNCE_CYCLES - 1)) begin
                filtrado <= ~filtrado;
                contador <= '0;
            end else begin
                contador <= contador + 1'b1;
            end
        end
    end

    assign pulso = filtrado & ~filtrado_q;

endmodule

// File: rtl/sequenciador_operandos.sv
// rtl/sequenciador_operandos.sv - captures A then B from switches, feeds the adder, registers {cout,sum}
// Optional subtract mode (B inverted, carry-in set) enabled by defining SUBTRACAO_EN.
module sequenciador_operandos
    import sequenciador_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LARGURA_OP-1:0]  chaves,
    input  logic                   botao,
    input  logic                   sub,
    sequenciador_operandos_if.master somador,
    output logic [LARGURA_RES-1:0] resultado,
    output logic                   resultado_valido,
    output logic [1:0]             estado
);
    estado_t               estado_atual;
    estado_t               estado_prox;
    logic                  pulso;
    logic                  carrega_a;
    logic                  carrega_b;
    logic                  grava;
    logic                  limpa;
    logic [LARGURA_OP-1:0] b_prox;
    logic                  cin_prox;

    filtro_botao #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_filtro (
        .clk   (clk),
        .reset (reset),
        .botao (botao),
        .pulso (pulso)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_atual <= ESPERA_A;
        end else begin
            estado_atual <= estado_prox;
        end
    end

    always_comb begin
        estado_prox = estado_atual;
        carrega_a   = 1'b0;
        carrega_b   = 1'b0;
        grava       = 1'b0;
        limpa       = 1'b0;
        case (estado_atual)
            ESPERA_A: if (pulso) begin
                carrega_a   = 1'b1;
                estado_prox = ESPERA_B;
            end
            ESPERA_B: if (pulso) begin
                carrega_b   = 1'b1;
                estado_prox = CALCULA;
            end
            CALCULA: begin
                grava       = 1'b1;
                estado_prox = MOSTRA;
            end
            MOSTRA: if (pulso) begin
                limpa       = 1'b1;
                estado_prox = ESPERA_A;
            end
            default: estado_prox = ESPERA_A;
        endcase
    end

    always_comb begin
        b_prox   = chaves;
`ifdef SUBTRACAO_EN
        cin_prox = sub;
        if (sub) begin
            b_prox = ~chaves;
        end
`else
        // sub has no effect in this build
        cin_prox = sub & 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            somador.a_op     <= '0;
            somador.b_op     <= '0;
            somador.cin      <= 1'b0;
            resultado        <= '0;
            resultado_valido <= 1'b0;
        end else if (limpa) begin
            somador.a_op     <= '0;
            somador.b_op     <= '0;
            somador.cin      <= 1'b0;
            resultado        <= '0;
            resultado_valido <= 1'b0;
        end else begin
            if (carrega_a) begin
                somador.a_op <= chaves;
            end
            if (carrega_b) begin
                somador.b_op <= b_prox;
                somador.cin  <= cin_prox;
            end
            // Adder inputs were stable for the whole CALCULA cycle.
            if (grava) begin
                resultado        <= {somador.cout_in, somador.soma_in};
                resultado_valido <= 1'b1;
            end
        end
    end

    assign estado = estado_atual;

endmodule

// File: tb/tb_sequenciador_operandos.sv
// tb/tb_sequenciador_operandos.sv - directed bench for the operand sequencer with a behavioural adder
module tb_sequenciador_operandos;
    localparam int D = 4;

    logic       clk;
    logic       reset;
    logic [3:0] chaves;
    logic       botao;
    logic       sub;
    logic [4:0] resultado;
    logic       resultado_valido;
    logic [1:0] estado;

    int vetores;
    int erros;

    sequenciador_operandos_if bus ();

    assign {bus.cout_in, bus.soma_in} = {1'b0, bus.a_op} + {1'b0, bus.b_op} + {4'b0, bus.cin};

    sequenciador_operandos #(
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .chaves           (chaves),
        .botao            (botao),
        .sub              (sub),
        .somador          (bus.master),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .estado           (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pressiona(input logic [3:0] valor);
        chaves = valor;
        botao  = 1'b1;
        repeat (D + 6) @(negedge clk);
        botao  = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vetores++; if (estado !== 2'd0) begin erros++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        vetores++; if (bus.a_op !== 4'd0) begin erros++; $display("FAIL reset_a_op got=%0d exp=0", bus.a_op); end
        vetores++; if (bus.b_op !== 4'd0) begin erros++; $display("FAIL reset_b_op got=%0d exp=0", bus.b_op); end
        vetores++; if (bus.cin !== 1'b0) begin erros++; $display("FAIL reset_cin got=%0b exp=0", bus.cin); end
        vetores++; if (resultado !== 5'd0) begin erros++; $display("FAIL reset_resultado got=%0d exp=0", resultado); end
        vetores++; if (resultado_valido !== 1'b0) begin erros++; $display("FAIL reset_valido got=%0b exp=0", resultado_valido); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_soma(input logic [3:0] a, input logic [3:0] b, input logic [4:0] esperado);
        pressiona(a);
        vetores++; if (estado !== 2'd1) begin erros++; $display("FAIL soma_estado_b got=%0d exp=1", estado); end
        vetores++; if (bus.a_op !== a) begin erros++; $display("FAIL soma_a_op got=%0d exp=%0d", bus.a_op, a); end
        chaves = b;
        botao  = 1'b1;
        repeat (7) @(negedge clk);
        vetores++; if (estado !== 2'd2) begin erros++; $display("FAIL soma_calcula got=%0d exp=2", estado); end
        vetores++; if (bus.b_op !== b) begin erros++; $display("FAIL soma_b_op got=%0d exp=%0d", bus.b_op, b); end
        vetores++; if (resultado_valido !== 1'b0) begin erros++; $display("FAIL soma_valido_cedo got=%0b exp=0", resultado_valido); end
        @(negedge clk);
        vetores++; if (estado !== 2'd3) begin erros++; $display("FAIL soma_mostra got=%0d exp=3", estado); end
        vetores++; if (resultado_valido !== 1'b1) begin erros++; $display("FAIL soma_valido got=%0b exp=1", resultado_valido); end
        vetores++; if (resultado !== esperado) begin erros++; $display("FAIL soma_resultado got=%0d exp=%0d", resultado, esperado); end
        repeat (D + 4) @(negedge clk);
        botao = 1'b0;
        repeat (D + 6) @(negedge clk);
        vetores++; if (estado !== 2'd3 || resultado !== esperado) begin
            erros++; $display("FAIL soma_retido estado=%0d res=%0d exp estado=3 res=%0d", estado, resultado, esperado);
        end
    endtask

    task automatic test_limpa;
        pressiona(4'hA);
        vetores++; if (estado !== 2'd0) begin erros++; $display("FAIL limpa_estado got=%0d exp=0", estado); end
        vetores++; if (resultado_valido !== 1'b0) begin erros++; $display("FAIL limpa_valido got=%0b exp=0", resultado_valido); end
        vetores++; if ({bus.a_op, bus.b_op, bus.cin, resultado} !== 14'd0) begin
            erros++; $display("FAIL limpa_saidas a=%0d b=%0d cin=%0b res=%0d exp all 0", bus.a_op, bus.b_op, bus.cin, resultado);
        end
    endtask

    task automatic test_subtracao;
        sub = 1'b0;
        pressiona(4'd7);
        sub = 1'b1;
        pressiona(4'd3);
        sub = 1'b0;
`ifdef SUBTRACAO_EN
        vetores++; if (bus.b_op !== 4'b1100) begin erros++; $display("FAIL sub_b_op got=%b exp=1100", bus.b_op); end
        vetores++; if (bus.cin !== 1'b1) begin erros++; $display("FAIL sub_cin got=%b exp=1", bus.cin); end
        vetores++; if (resultado !== 5'b10100) begin erros++; $display("FAIL sub_resultado got=%b exp=10100", resultado); end
`else
        vetores++; if (bus.b_op !== 4'b0011) begin erros++; $display("FAIL sub_ignorado_b_op got=%b exp=0011", bus.b_op); end
        vetores++; if (bus.cin !== 1'b0) begin erros++; $display("FAIL sub_ignorado_cin got=%b exp=0", bus.cin); end
        vetores++; if (resultado !== 5'b01010) begin erros++; $display("FAIL sub_ignorado_resultado got=%b exp=01010", resultado); end
`endif
        vetores++; if (resultado_valido !== 1'b1) begin erros++; $display("FAIL sub_valido got=%b exp=1", resultado_valido); end
    endtask

    task automatic test_bounce;
        chaves = 4'd9;
        for (int i = 0; i < 5; i++) begin
            botao = 1'b1;
            repeat (3) @(negedge clk);
            botao = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (D + 6) @(negedge clk);
        vetores++; if (estado !== 2'd0) begin erros++; $display("FAIL bounce_estado got=%0d exp=0", estado); end
        vetores++; if (bus.a_op !== 4'd0) begin erros++; $display("FAIL bounce_a_op got=%0d exp=0", bus.a_op); end
    endtask

    task automatic test_held;
        chaves = 4'd6;
        botao  = 1'b1;
        repeat (100) @(negedge clk);
        vetores++; if (estado !== 2'd1) begin erros++; $display("FAIL held_estado got=%0d exp=1", estado); end
        vetores++; if (bus.a_op !== 4'd6) begin erros++; $display("FAIL held_a_op got=%0d exp=6", bus.a_op); end
        botao = 1'b0;
        repeat (20) @(negedge clk);
        vetores++; if (estado !== 2'd1) begin erros++; $display("FAIL held_release got=%0d exp=1", estado); end
    endtask

    task automatic test_reset_async;
        #2;
        reset = 1'b1;
        #1;
        vetores++; if (estado !== 2'd0) begin erros++; $display("FAIL async_estado got=%0d exp=0", estado); end
        vetores++; if (bus.a_op !== 4'd0) begin erros++; $display("FAIL async_a_op got=%0d exp=0", bus.a_op); end
        vetores++; if (resultado_valido !== 1'b0) begin erros++; $display("FAIL async_valido got=%0b exp=0", resultado_valido); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vetores = 0;
        erros   = 0;
        reset   = 1'b1;
        chaves  = 4'd0;
        botao   = 1'b0;
        sub     = 1'b0;
        @(negedge clk);
        test_reset;
        test_soma(4'd5, 4'd3, 5'b01000);
        test_limpa;
        test_soma(4'd9, 4'd8, 5'b10001);
        test_limpa;
        test_soma(4'd15, 4'd15, 5'b11110);
        test_limpa;
        test_subtracao;
        test_limpa;
        test_bounce;
        test_held;
        test_reset_async;
        test_soma(4'd0, 4'd0, 5'b00000);
        test_limpa;
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
